// File: rtl/pkt_forwarder_pkg.sv
`default_nettype none
// =============================================================================
// Module   : pkt_forwarder_pkg
// Brief    : Shared FSM encoding and send/drop result constants.
// Revision : 1.0 - initial release
// =============================================================================
package pkt_forwarder_pkg;

   typedef enum logic [1:0] {
      WAIT_RESULT = 2'd0,
      FORWARD     = 2'd1,
      DROP        = 2'd2
   } fwd_state_e;

   // The parser writes these values into the decision FIFO.
   localparam logic RESULT_SEND = 1'b1;
   localparam logic RESULT_DROP = 1'b0;

   function automatic int axis_payload_width(input int data_width, input int tuser_width);
      return data_width + data_width / 8 + tuser_width + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_forwarder_if.sv
`default_nettype none
// =============================================================================
// Module   : pkt_forwarder_if
// Brief    : AXI4-Stream bundle with master/slave modports.
// Revision : 1.0 - initial release
// =============================================================================
interface pkt_forwarder_if #(
   parameter int DATA_WIDTH  = 256,
   parameter int TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;

   modport master (
      output tdata, tstrb, tuser, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tuser, tvalid, tlast,
      output tready
   );
endinterface
`default_nettype wire

// File: rtl/pkt_forwarder_skid.sv
`default_nettype none
// =============================================================================
// Module   : axis_skid_reg
// Brief    : Two-entry registered stream slice; in_ready depends only on state.
// Revision : 1.0 - initial release
// =============================================================================
module axis_skid_reg #(
   parameter int WIDTH = 417
) (
   input  wire              clk,
   input  wire              rst,
   input  wire [WIDTH-1:0]  in_data,
   input  wire              in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  wire              out_ready
);
   logic [WIDTH-1:0] r_slot0;
   logic [WIDTH-1:0] r_slot1;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_rd_ptr ? r_slot1 : r_slot0;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot0  <= '0;
         r_slot1  <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            if (r_wr_ptr) begin
               r_slot1 <= in_data;
            end else begin
               r_slot0 <= in_data;
            end
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/pkt_forwarder.sv
`default_nettype none
// =============================================================================
// Module   : pkt_forwarder
// Brief    : Pops one send/drop decision per packet, then forwards or discards it.
// Revision : 1.0 - initial release
// =============================================================================
module pkt_forwarder
   import pkt_forwarder_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int CNT_WIDTH            = 32
) (
   input  wire                  axi_aclk,
   input  wire                  axi_areset,
   pkt_forwarder_if.slave       s_axis,
   pkt_forwarder_if.master      m_axis,
   input  wire                  result_dout,
   input  wire                  result_empty,
   output logic                 result_rd_en,
   output logic [CNT_WIDTH-1:0] fwd_count,
   output logic [CNT_WIDTH-1:0] drop_count
);
   localparam int c_s_payload_width = axis_payload_width(C_S_AXIS_DATA_WIDTH, C_S_AXIS_TUSER_WIDTH);
   localparam int c_m_payload_width = axis_payload_width(C_M_AXIS_DATA_WIDTH, C_M_AXIS_TUSER_WIDTH);

   fwd_state_e                   r_state;
   fwd_state_e                   w_next_state;
   logic [CNT_WIDTH-1:0]         r_fwd_count;
   logic [CNT_WIDTH-1:0]         r_drop_count;
   logic                         w_fwd_inc;
   logic                         w_drop_inc;
   logic                         w_s_tready;
   logic                         w_skid_in_valid;
   logic                         w_skid_in_ready;
   logic                         w_skid_out_valid;
   logic [c_s_payload_width-1:0] w_s_payload;
   logic [c_m_payload_width-1:0] w_in_payload;
   logic [c_m_payload_width-1:0] w_out_payload;

   assign w_s_payload  = {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
   assign w_in_payload = w_s_payload;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_state <= WAIT_RESULT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The pop is gated by reset so a stale FIFO head is never consumed while held.
   always_comb begin
      w_next_state    = r_state;
      result_rd_en    = 1'b0;
      w_s_tready      = 1'b0;
      w_skid_in_valid = 1'b0;
      w_fwd_inc       = 1'b0;
      w_drop_inc      = 1'b0;
      case (r_state)
         WAIT_RESULT: begin
            if (!result_empty && !axi_areset) begin
               result_rd_en = 1'b1;
               w_next_state = (result_dout == RESULT_SEND) ? FORWARD : DROP;
            end
         end
         FORWARD: begin
            w_s_tready = w_skid_in_ready;
            if (s_axis.tvalid && w_skid_in_ready) begin
               w_skid_in_valid = 1'b1;
               if (s_axis.tlast) begin
                  w_fwd_inc    = 1'b1;
                  w_next_state = WAIT_RESULT;
               end
            end
         end
         DROP: begin
            w_s_tready = 1'b1;
            if (s_axis.tvalid && s_axis.tlast) begin
               w_drop_inc   = 1'b1;
               w_next_state = WAIT_RESULT;
            end
         end
         default: w_next_state = WAIT_RESULT;
      endcase
   end

   assign s_axis.tready = w_s_tready;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_fwd_count  <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_fwd_inc) begin
            r_fwd_count <= r_fwd_count + CNT_WIDTH'(1);
         end
         if (w_drop_inc) begin
            r_drop_count <= r_drop_count + CNT_WIDTH'(1);
         end
      end
   end

   assign fwd_count  = r_fwd_count;
   assign drop_count = r_drop_count;

   axis_skid_reg #(
      .WIDTH (c_m_payload_width)
   ) u_skid (
      .clk       (axi_aclk),
      .rst       (axi_areset),
      .in_data   (w_in_payload),
      .in_valid  (w_skid_in_valid),
      .in_ready  (w_skid_in_ready),
      .out_data  (w_out_payload),
      .out_valid (w_skid_out_valid),
      .out_ready (m_axis.tready)
   );

   assign m_axis.tvalid = w_skid_out_valid;
   assign m_axis.tdata  = w_out_payload[C_M_AXIS_DATA_WIDTH-1:0];
   assign m_axis.tstrb  = w_out_payload[C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH/8];
   assign m_axis.tuser  = w_out_payload[C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH/8 +: C_M_AXIS_TUSER_WIDTH];
   assign m_axis.tlast  = w_out_payload[c_m_payload_width-1];
endmodule
`default_nettype wire

// File: tb/tb_pkt_forwarder.sv
`default_nettype none
// =============================================================================
// Module   : tb_pkt_forwarder
// Brief    : Directed bench with a packet-level send/drop model and scoreboard.
// Revision : 1.0 - initial release
// =============================================================================
module tb_pkt_forwarder;
   import pkt_forwarder_pkg::*;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = DW / 8;
   localparam int CW = 4;
   localparam int PW = DW + SW + UW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          result_dout;
   logic          result_empty;
   logic          result_rd_en;
   logic [CW-1:0] fwd_count;
   logic [CW-1:0] drop_count;

   pkt_forwarder_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
   pkt_forwarder_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

   pkt_forwarder #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .CNT_WIDTH            (CW)
   ) dut (
      .axi_aclk     (clk),
      .axi_areset   (rst),
      .s_axis       (s_if),
      .m_axis       (m_if),
      .result_dout  (result_dout),
      .result_empty (result_empty),
      .result_rd_en (result_rd_en),
      .fwd_count    (fwd_count),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [PW-1:0] exp_q[$];
   bit            res_q[$];
   int            exp_fwd  = 0;
   int            exp_drop = 0;
   int            pops     = 0;
   int            rx_beats = 0;
   int            rx_last  = 0;
   int            tready_mode = 0;
   int            pat_i = 0;
   logic [PW-1:0] pay;
   logic [PW-1:0] prev_pay;
   bit            prev_stall = 1'b0;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic upd_res();
      result_empty = (res_q.size() == 0);
      result_dout  = (res_q.size() != 0) ? res_q[0] : 1'b0;
   endtask

   task automatic push_res(input bit r);
      res_q.push_back(r);
      upd_res();
   endtask

   function automatic logic [PW-1:0] mk_beat(input int pkt, input int idx, input bit last);
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [UW-1:0] u;
      d = '0;
      d[31:0] = idx;
      d[DW-1 -: 32] = pkt;
      s = {SW{1'b1}} >> (idx % 4);
      u = '0;
      u[31:0] = pkt * 65536 + idx;
      return {last, u, s, d};
   endfunction

   // Decision FIFO: fall-through head, popped on the edge that sees result_rd_en.
   always @(posedge clk) begin
      if (result_rd_en) begin
         pops++;
         check("pop_nonempty", PW'(res_q.size() != 0), PW'(1));
         if (res_q.size() != 0) begin
            void'(res_q.pop_front());
         end
      end
      #1 upd_res();
   end

   // Downstream ready: always 1, or the 1,0,0 repeating pattern.
   always @(posedge clk) begin
      #1;
      if (tready_mode == 0) begin
         m_if.tready = 1'b1;
      end else begin
         m_if.tready = (pat_i % 3 == 0);
         pat_i++;
      end
   end

   // Scoreboard: every output handshake must match the model's next forwarded beat.
   always @(negedge clk) begin
      pay = {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata};
      if (!rst) begin
         check("fwd_count", PW'(fwd_count), PW'(exp_fwd % (1 << CW)));
         check("drop_count", PW'(drop_count), PW'(exp_drop % (1 << CW)));
         if (prev_stall) begin
            check("stall_valid", PW'(m_if.tvalid), PW'(1));
            check("stall_payload", pay, prev_pay);
         end
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got %0h required no beat", pay);
            end else begin
               check("beat", pay, exp_q.pop_front());
            end
            rx_beats++;
            if (m_if.tlast) rx_last++;
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_pay   = pay;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic drive_beat(input int pkt, input int idx, input bit last, input bit fwd);
      logic [PW-1:0] b;
      int            t;
      bit            ok;
      b = mk_beat(pkt, idx, last);
      s_if.tdata  = b[DW-1:0];
      s_if.tstrb  = b[DW +: SW];
      s_if.tuser  = b[DW + SW +: UW];
      s_if.tlast  = b[PW-1];
      s_if.tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_if.tready && t < 200) begin
         @(negedge clk);
         t++;
      end
      ok = s_if.tready;
      check("accept", PW'(ok), PW'(1));
      @(posedge clk);
      #1;
      if (ok) begin
         if (fwd) exp_q.push_back(b);
         if (last) begin
            if (fwd) exp_fwd++;
            else     exp_drop++;
         end
      end
   endtask

   task automatic send_pkt(input int pkt, input int nb, input bit fwd);
      for (int i = 0; i < nb; i++) begin
         drive_beat(pkt, i, (i == nb - 1), fwd);
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_if.tvalid) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check(name, PW'(exp_q.size()), PW'(0));
   endtask

   task automatic clear_model();
      exp_q.delete();
      res_q.delete();
      upd_res();
      exp_fwd  = 0;
      exp_drop = 0;
   endtask

   task automatic apply_reset();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      rst = 1'b1;
      clear_model();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tdata  = '0;
      s_if.tstrb  = '0;
      s_if.tuser  = '0;
      upd_res();
      #1;
      // Decisions for the first test wait in the FIFO while reset is held.
      push_res(1'b1);
      push_res(1'b0);
      push_res(1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd_en", PW'(result_rd_en), PW'(0));
      check("rst_s_tready", PW'(s_if.tready), PW'(0));
      check("rst_m_tvalid", PW'(m_if.tvalid), PW'(0));
      check("rst_m_payload", {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata}, PW'(0));
      check("rst_fwd", PW'(fwd_count), PW'(0));
      check("rst_drop", PW'(drop_count), PW'(0));
      rst = 1'b0;

      // Results [1,0,1], three 3-beat packets.
      send_pkt(1, 3, 1'b1);
      send_pkt(2, 3, 1'b0);
      send_pkt(3, 3, 1'b1);
      wait_drain("t1_drain");
      check("t1_fwd", PW'(fwd_count), PW'(2));
      check("t1_drop", PW'(drop_count), PW'(1));
      check("t1_pops", PW'(pops), PW'(3));
      check("t1_rx_beats", PW'(rx_beats), PW'(6));
      check("t1_rx_last", PW'(rx_last), PW'(2));

      // Packet waiting while the decision FIFO is empty must be held.
      s_if.tdata  = '0;
      s_if.tvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t2_hold_tready", PW'(s_if.tready), PW'(0));
      end
      @(posedge clk);
      #1;
      push_res(1'b1);
      send_pkt(4, 3, 1'b1);
      wait_drain("t2_drain");
      check("t2_fwd", PW'(fwd_count), PW'(3));
      check("t2_pops", PW'(pops), PW'(4));

      // 6-beat packet under a 1,0,0 ready pattern.
      tready_mode = 1;
      push_res(1'b1);
      send_pkt(5, 6, 1'b1);
      wait_drain("t3_drain");
      tready_mode = 0;
      check("t3_fwd", PW'(fwd_count), PW'(4));
      check("t3_rx_beats", PW'(rx_beats), PW'(15));

      // Back-to-back single-beat packets, results [0,0,1,1].
      push_res(1'b0);
      push_res(1'b0);
      push_res(1'b1);
      push_res(1'b1);
      send_pkt(6, 1, 1'b0);
      send_pkt(7, 1, 1'b0);
      send_pkt(8, 1, 1'b1);
      send_pkt(9, 1, 1'b1);
      wait_drain("t4_drain");
      check("t4_drop", PW'(drop_count), PW'(3));
      check("t4_fwd", PW'(fwd_count), PW'(6));
      check("t4_rx_beats", PW'(rx_beats), PW'(17));
      check("t4_rx_last", PW'(rx_last), PW'(6));

      // Asynchronous reset while beat 2 of 4 is on the input.
      push_res(1'b1);
      drive_beat(10, 0, 1'b0, 1'b1);
      drive_beat(10, 1, 1'b0, 1'b1);
      s_if.tdata = '1;
      #2;
      rst = 1'b1;
      #1;
      check("t5_m_tvalid", PW'(m_if.tvalid), PW'(0));
      check("t5_fwd", PW'(fwd_count), PW'(0));
      check("t5_drop", PW'(drop_count), PW'(0));
      check("t5_s_tready", PW'(s_if.tready), PW'(0));
      clear_model();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5_idle_tready", PW'(s_if.tready), PW'(0));
      check("t5_idle_rd_en", PW'(result_rd_en), PW'(0));
      @(posedge clk);
      #1;
      push_res(1'b1);
      send_pkt(11, 2, 1'b1);
      wait_drain("t5_drain");
      check("t5_fwd_after", PW'(fwd_count), PW'(1));

      // Counter wrap with a 4-bit counter: 17 packets leave 1.
      apply_reset();
      for (int i = 0; i < 17; i++) push_res(1'b1);
      for (int i = 0; i < 17; i++) send_pkt(20 + i, 1, 1'b1);
      wait_drain("t6_drain");
      check("t6_fwd_wrap", PW'(fwd_count), PW'(1));
      check("t6_drop", PW'(drop_count), PW'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pkt_forwarder.md
Name: pkt_forwarder

Overview:
- Consumer end of the parser's per-packet decision FIFO. For each packet, pops one send/drop bit from the result FIFO, then reads that packet from the buffered packet stream.
- Forwards the packet beat-for-beat to the downstream AXI4-Stream master, or silently discards it.
- Sits after the parser/filter pair, ahead of the output queues.
- Keeps forwarded/dropped packet counters for the register block.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master stream data width.
- C_S_AXIS_DATA_WIDTH, 256, slave stream data width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal C_M_AXIS_TUSER_WIDTH.
- CNT_WIDTH, 32, width of the packet counters.

Ports:
- axi_aclk  in  1  sole clock; all logic is rising-edge.
- axi_areset  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  buffered packet data.
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- s_axis_tlast  in  1  last beat of packet.
- result_dout  in  1  head of decision FIFO; 1=send, 0=drop. Fall-through: valid whenever !result_empty.
- result_empty  in  1  decision FIFO empty.
- result_rd_en  out  1  pop decision FIFO.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  downstream data.
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  downstream strobes.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  downstream sideband.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  downstream last.
- fwd_count  out  CNT_WIDTH  packets forwarded; counts the tlast beat accepted in FORWARD.
- drop_count  out  CNT_WIDTH  packets dropped; counts the tlast beat accepted in DROP.

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream):
  - state=WAIT_RESULT.
  - m_axis_tvalid=0; m_axis data, tstrb, tuser and tlast registers=0.
  - result_rd_en=0, s_axis_tready=0, both counters=0.
- FSM states: WAIT_RESULT, FORWARD, DROP.
- WAIT_RESULT:
  - s_axis_tready=0.
  - When !result_empty: result_rd_en=1 for exactly one cycle (combinational, same cycle).
  - Next state is FORWARD if result_dout=1, else DROP.
  - Decision-to-first-beat latency: one cycle.
- FORWARD:
  - Output is a 2-entry skid register (axis_skid_reg). s_axis_tready = skid not full (registered, no combinational path from m_axis_tready).
  - Each accepted beat is pushed unchanged into the skid register.
  - On accepted beat with s_axis_tlast=1: fwd_count++ and go to WAIT_RESULT. The skid register keeps draining independently.
  - The next packet's result pop may occur in the cycle after the tlast beat.
- DROP:
  - s_axis_tready=1; beats are discarded and the skid register is untouched.
  - On accepted tlast: drop_count++ and go to WAIT_RESULT.
- Single-beat packets (tlast on first beat) behave as above: one beat forwarded or discarded, counter +1.
- Pipeline behaviour:
  - Skid depth 2 gives full throughput, one beat per cycle with m_axis_tready held 1.
  - First-beat latency from s_axis acceptance to m_axis_tvalid: 1 cycle.
  - m_axis_* stays stable while tvalid&!tready (AXI4-Stream rule).
- Counters wrap modulo 2^CNT_WIDTH.
- Boundary conditions:
  - Result FIFO empty while a packet is waiting: the packet is held (tready=0), never dropped.
  - s_axis_tvalid low mid-packet: stay in state, no counter change.
  - Reset mid-packet: outputs cleared immediately. Downstream may see a truncated packet; this is accepted because upstream FIFOs are reset by the same signal.
- A result is never popped outside WAIT_RESULT; at most one pop per packet.

Decomposition:
- Shared package: FSM state encoding (2-bit WAIT_RESULT=0, FORWARD=1, DROP=2) and the RESULT_SEND=1'b1 / RESULT_DROP=1'b0 constants. The parser uses the same result constants.
- One sub-module, axis_skid_reg: 2-entry registered AXI4-Stream slice with parameterised payload width {tlast,tuser,tstrb,tdata}, signals in_ready/out_valid.

Test Plan:
- Results [1,0,1]; three 3-beat packets with tdata=beat index; m_axis_tready=1. Expect packets 1 and 3 on m_axis with identical data, strobes and tlast; fwd_count=2; drop_count=1; result_rd_en pulsed exactly 3 times.
- Packet valid with result_empty=1 for 10 cycles, then push 1. Expect s_axis_tready=0 for all 10 cycles, then full packet forwarded; fwd_count=1.
- Forward a 6-beat packet; m_axis_tready toggles 1,0,0,1,... Expect no beat lost or duplicated, m_axis payload stable while stalled, order preserved.
- Back-to-back single-beat packets with results [0,0,1,1]. Expect drop_count=2, fwd_count=2, and exactly two m_axis beats, each with tlast=1.
- Assert axi_areset asynchronously mid-FORWARD on beat 2 of 4. Expect m_axis_tvalid=0 before the next clock edge, counters=0, and state WAIT_RESULT after release.
- Preload fwd_count near wrap (CNT_WIDTH=4), forward 17 packets. Expect fwd_count=1.
